// File: rtl/regfile_bypass.sv
// Decode-stage register file: two registered read ports with write bypass,
// byte-enabled write port, optional hardwired zero entry and a bulk-clear
// sequencer that walks every entry once.
//
// state | meaning
// IDLE  | normal operation, writes accepted, reads bypassed
// CLEAR | zeroing entry[ptr] each edge, writes dropped, reads return 0
module regfile_bypass #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    ReadRegister1,
  input  logic [ADDR_W-1:0]    ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic                 Write,
  input  logic [ADDR_W-1:0]    WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [WIDTH/8-1:0]   ByteEnable,
  input  logic                 Clear,
  output logic                 Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = WIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_acc;
  logic [WIDTH-1:0]  wr_merged;
  logic [WIDTH-1:0]  rd1_nxt, rd2_nxt;

  assign Busy = (state == CLEAR);

  // State register and clear pointer; pointer wraps to 0 on the last entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // Next-state: leave CLEAR on the edge that zeroes the final entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Clear) state_nxt = CLEAR;
      CLEAR:   if (ptr == {ADDR_W{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write acceptance, byte merge and bypassed read selection.
  always_comb begin
    wr_acc    = (state == IDLE) && Write &&
                !((ZERO_REG != 0) && (WriteRegister == '0));
    wr_merged = mem[WriteRegister];
    for (int b = 0; b < NB; b++) begin
      if (ByteEnable[b]) wr_merged[8*b +: 8] = WriteData[8*b +: 8];
    end

    rd1_nxt = mem[ReadRegister1];
    if (wr_acc && (ReadRegister1 == WriteRegister)) rd1_nxt = wr_merged;
    if ((ZERO_REG != 0) && (ReadRegister1 == '0)) rd1_nxt = '0;
    if (state == CLEAR) rd1_nxt = '0;

    rd2_nxt = mem[ReadRegister2];
    if (wr_acc && (ReadRegister2 == WriteRegister)) rd2_nxt = wr_merged;
    if ((ZERO_REG != 0) && (ReadRegister2 == '0)) rd2_nxt = '0;
    if (state == CLEAR) rd2_nxt = '0;
  end

  // Register array: clear engine has priority, writes only land in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      mem[WriteRegister] <= wr_merged;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
    end else begin
      ReadData1 <= rd1_nxt;
      ReadData2 <= rd2_nxt;
    end
  end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised successor to the datapath register file: a WIDTH x 2^ADDR_W register array with two registered read ports, one byte-enabled write port, write-to-read bypass, optional hardwired zero register and a sequenced bulk-clear engine. Sits in the decode stage of the MIPS datapath, feeding the ALU operand registers and written back from the WB stage.

## Interface

- WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; DEPTH = 2^ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous active-high reset.
- ReadRegister1  input  ADDR_W  read port 1 address.
- ReadRegister2  input  ADDR_W  read port 2 address.
- ReadData1  output  WIDTH  registered read port 1 data.
- ReadData2  output  WIDTH  registered read port 2 data.
- Write  input  1  write request, sampled each rising edge.
- WriteRegister  input  ADDR_W  write address.
- WriteData  input  WIDTH  write data.
- ByteEnable  input  WIDTH/8  per-byte write enable; bit i covers WriteData[8i+7:8i].
- Clear  input  1  bulk-clear request, sampled in IDLE.
- Busy  output  1  clear sequence in progress.

## Operation

- Reset: all entries 0, ReadData1/2 = 0, Busy = 0, state IDLE, clear pointer 0. Reset mid-clear aborts the sequence; result identical to a fresh reset.
- States: IDLE, CLEAR. IDLE -> CLEAR when Clear = 1 at a rising edge. CLEAR -> IDLE at the edge that zeroes entry DEPTH-1. Busy = (state == CLEAR), registered.
- Write (IDLE only): at rising edge with Write = 1, entry[WriteRegister] byte i <= WriteData byte i where ByteEnable[i] = 1; other bytes unchanged. ByteEnable = 0 is a no-op. Write to entry 0 dropped when ZERO_REG = 1.
- Write in CLEAR: dropped, no side effect.
- Read (IDLE): at each rising edge ReadDataN <= value of entry[ReadRegisterN] after this edge's write, i.e. bypassed: if an accepted write targets the same address, ReadDataN gets the byte-merged value (new bytes where enabled, old bytes elsewhere). Entry 0 with ZERO_REG = 1 reads 0.
- Read in CLEAR: ReadDataN <= 0 at every edge while Busy = 1 before the edge.
- Clear sequence: pointer starts at 0; at each edge in CLEAR, entry[pointer] <= 0, pointer increments; pointer wraps to 0 on return to IDLE.
- Clear during CLEAR ignored. Clear and Write in the same IDLE cycle: write is performed and bypassed to reads that edge; the clear then zeroes the entry.

## Timing

- Read latency: 1 cycle; address at edge N, data valid after edge N, held until next edge.
- Write visibility: same edge via bypass; 0-cycle read-after-write hazard.
- Clear: Clear sampled at edge N; Busy = 1 after edge N; entries 0..DEPTH-1 zeroed at edges N+1..N+DEPTH; Busy = 0 after edge N+DEPTH. Busy high exactly DEPTH cycles; first accepted write at edge N+DEPTH+1.
- Reset asserted asynchronously forces outputs to 0 immediately, independent of clk.

## Test plan

- Reset: assert reset mid-cycle -> ReadData1/2 = 0 and Busy = 0 without a clock edge; all 32 entries then read 0.
- Write/read: write 0xDEADBEEF to r5, ByteEnable 0xF; next cycle read r5 on both ports -> 0xDEADBEEF on ReadData1 and ReadData2.
- Byte merge + bypass: r7 = 0x11223344; same edge Write r7 = 0xAABBCCDD, ByteEnable 0b0101, ReadRegister1 = 7 -> ReadData1 = 0x11BB33DD after that edge.
- Zero register: write 0xFFFFFFFF to r0 -> read r0 = 0 (ZERO_REG = 1); with ZERO_REG = 0 -> 0xFFFFFFFF.
- Clear: fill r1..r31 nonzero, pulse Clear with a simultaneous write r3 = 0x5 -> Busy high 32 cycles, writes during Busy dropped, ReadData = 0 during Busy, all entries 0 afterwards.
- Reset mid-clear: assert reset at cycle 10 of CLEAR -> Busy = 0, state IDLE; a new Clear starts from pointer 0 and lasts 32 cycles.
